serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial two's-complement subtractor that computes A − B one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the inverse-operation counterpart to the team's serial adder and is built from the same parts: parallel operand capture, serial bit processing and parallel result collection. It adds an explicit start/busy/done handshake. It sits beside the serial adder in the Week 2 arithmetic datapath and is driven by the same top-level test harness.

## Interface
- WIDTH, 8: operand and result width in bits; legal values are 2..16.
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  request a subtraction; sampled only in IDLE.
- A  input  WIDTH  minuend; captured on the accepting edge.
- B  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle pulse; diff and borrow_out are valid.
- diff  output  WIDTH  result A − B modulo 2^WIDTH.
- borrow_out  output  1  final borrow; 1 when A < B as unsigned values.
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVERFLOW_EN.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - start=1 loads A and B into the operand shift registers, clears the borrow flop, the bit counter and the diff register, then moves to SHIFT.
  - start=0 stays in IDLE.
- SHIFT, on each edge:
  - d = a0 ^ b0 ^ bw.
  - bw_next = (~a0 & b0) | (~(a0 ^ b0) & bw).
  - d is shifted into the diff register from the MSB end, and both operand registers shift right by one.
  - The counter increments. When the counter reaches WIDTH−1 on this edge, the next state is DONE.
- DONE: done=1 for exactly one cycle, then the FSM returns to IDLE unconditionally.
- start is ignored in SHIFT and DONE. It is not queued.
- A and B are don't-care after the capture edge. Changing them mid-operation has no effect.
- diff and borrow_out hold their last result until the next accepted start clears them.
- Width rules:
  - The counter is $clog2(WIDTH)+1 bits wide.
  - There is no sign extension. diff is the wrapped WIDTH-bit result.
  - borrow_out is the borrow out of bit WIDTH−1.

## Timing
- Reset values: busy=0, done=0, diff=0, borrow_out=0, ovf=0, state=IDLE, counter=0.
- resetn low at any time, including mid-SHIFT, clears every output and register immediately. The aborted operation produces no done pulse.
- Latency: start sampled at edge k leads to busy=1 from edge k through edge k+WIDTH. State is DONE with done=1 from edge k+WIDTH to edge k+WIDTH+1.
- The earliest next accepted start is at edge k+WIDTH+2, the first IDLE cycle. If start is held high continuously, operations run back to back with one IDLE cycle between them.
- busy and done are never high in the same cycle.

## Configuration
- SERIAL_SUB_OVERFLOW_EN defined:
  - The ovf port exists.
  - ovf = (a_msb ^ b_msb) & (a_msb ^ d_msb), computed on the last SHIFT edge.
  - ovf is valid with done and holds like diff.
- SERIAL_SUB_OVERFLOW_EN undefined:
  - The ovf port and its logic are absent.
  - All other behaviour is identical.

## Structure
- The shared package serial_arith_pkg holds:
  - the state typedef (IDLE, SHIFT, DONE);
  - the default width constant (8);
  - the full-subtractor difference and borrow functions, shared with serial-adder variants.
- The natural sub-module is full_subtractor: a combinational 1-bit cell with inputs a, b, bin and outputs d, bout.
- Operand registers, the borrow flop, the counter, the diff collector and the FSM live in serial_subtractor.

## Test plan
- A=0x5A, B=0x23, start pulsed → done 8 cycles later; diff=0x37, borrow_out=0.
- A=0x10, B=0x20 → diff=0xF0, borrow_out=1. A=0xFF, B=0xFF → diff=0x00, borrow_out=0.
- With SERIAL_SUB_OVERFLOW_EN:
  - A=0x80, B=0x01 → diff=0x7F, ovf=1.
  - A=0x00, B=0x01 → diff=0xFF, borrow_out=1, ovf=0.
- start re-pulsed at cycle 3 of SHIFT with different A/B → ignored; result matches the first operands; exactly one done pulse.
- resetn low during SHIFT cycle 4 → all outputs 0 asynchronously and no done pulse. A following A=0x09, B=0x04 run gives diff=0x05.
- start held high for 3 operations → done pulses spaced WIDTH+2 cycles apart, each diff correct for the operands present at its capture edge.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared types and full-subtractor helpers for the serial arithmetic units.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;

  function automatic logic fs_diff(
    input logic a,
    input logic b,
    input logic bin
  );
    return a ^ b ^ bin;
  endfunction

  function automatic logic fs_borrow(
    input logic a,
    input logic b,
    input logic bin
  );
    return (~a & b) | (~(a ^ b) & bin);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor.
// ovf exists only when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             ovf;
`endif

  modport master (
    output start, A, B,
`ifdef SERIAL_SUB_OVERFLOW_EN
    input  ovf,
`endif
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, A, B,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output ovf,
`endif
    output busy, done, diff, borrow_out
  );

endinterface

// File: rtl/full_subtractor.sv
// Combinational 1-bit full subtractor cell.
module full_subtractor
  import serial_arith_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = fs_diff(a, b, bin);
  assign bout = fs_borrow(a, b, bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one full-subtractor cell.
// Optional signed overflow flag: SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
)(
  input  logic               clk,
  input  logic               resetn,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_bw;
  logic             r_busy;
  logic             r_done;
  logic             w_d;
  logic             w_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             r_ovf;
`endif

  full_subtractor u_fs (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_bw),
    .d    (w_d),
    .bout (w_bout)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_diff  <= '0;
      r_cnt   <= '0;
      r_bw    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= SHIFT;
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_diff  <= '0;
            r_cnt   <= '0;
            r_bw    <= 1'b0;
            r_busy  <= 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
            r_ovf   <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          r_diff <= {w_d, r_diff[WIDTH-1:1]};
          r_a    <= r_a >> 1;
          r_b    <= r_b >> 1;
          r_bw   <= w_bout;
          r_cnt  <= r_cnt + 1'b1;
          // last edge: operand LSBs are now the original MSBs
          if (r_cnt == LAST) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
            r_ovf   <= (r_a[0] ^ r_b[0]) & (r_a[0] ^ w_d);
`endif
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.diff       = r_diff;
  assign bus.borrow_out = r_bw;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign bus.ovf        = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic model.
module tb_serial_subtractor;
  import serial_arith_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   fails = 0;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int d, output int bw, output int ov);
    int ur;
    int sr;
    ur = int'(a) - int'(b);
    sr = int'($signed(a)) - int'($signed(b));
    d  = ur & ((1 << W) - 1);
    bw = (ur < 0) ? 1 : 0;
    ov = (sr > (1 << (W - 1)) - 1 || sr < -(1 << (W - 1))) ? 1 : 0;
  endtask

  task automatic check_result(input string tag,
                              input logic [W-1:0] a, input logic [W-1:0] b);
    int d, bw, ov;
    model(a, b, d, bw, ov);
    check({tag, "_diff"}, int'(bus.diff), d);
    check({tag, "_borrow"}, int'(bus.borrow_out), bw);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check({tag, "_ovf"}, int'(bus.ovf), ov);
`else
    if (ov < 0) $display("unreachable");
`endif
  endtask

  task automatic op(input string tag, input logic [W-1:0] a,
                    input logic [W-1:0] b, input bit repulse);
    int lat;
    int extra;
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({tag, "_busy_k"}, int'(bus.busy), 1);
    check({tag, "_done_k"}, int'(bus.done), 0);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 3 * W) begin
      if (repulse && lat == 2) begin
        bus.start = 1'b1;
        bus.A = ~a;
        bus.B = a ^ 8'h5C;
      end else if (repulse && lat == 3) begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy === 1'b1 && bus.done === 1'b1)
        check({tag, "_busy_and_done"}, 1, 0);
    end
    check({tag, "_latency"}, lat, W);
    check({tag, "_busy_at_done"}, int'(bus.busy), 0);
    check_result(tag, a, b);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, int'(bus.done), 0);
    check_result({tag, "_hold"}, a, b);
    if (repulse) begin
      extra = 0;
      repeat (2 * W) begin
        @(posedge clk);
        #1;
        if (bus.done === 1'b1) extra++;
      end
      check({tag, "_extra_done"}, extra, 0);
    end
  endtask

  logic [W-1:0] qa [64];
  logic [W-1:0] qb [64];

  initial begin
    int cap;
    int n;
    int seen;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    #12;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_diff", int'(bus.diff), 0);
    check("rst_borrow", int'(bus.borrow_out), 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("rst_ovf", int'(bus.ovf), 0);
`endif
    @(negedge clk);
    resetn = 1'b1;

    op("5a_23", 8'h5A, 8'h23, 1'b0);
    check("5a_23_lit", int'(bus.diff), 'h37);
    op("10_20", 8'h10, 8'h20, 1'b0);
    check("10_20_lit", int'(bus.diff), 'hF0);
    op("ff_ff", 8'hFF, 8'hFF, 1'b0);
    op("80_01", 8'h80, 8'h01, 1'b0);
    check("80_01_lit", int'(bus.diff), 'h7F);
    op("00_01", 8'h00, 8'h01, 1'b0);
    check("00_01_lit", int'(bus.borrow_out), 1);
    op("repulse", 8'hC3, 8'h4E, 1'b1);

    // abort mid-SHIFT with an asynchronous reset
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = 8'hF0;
    bus.B = 8'h0F;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_diff", int'(bus.diff), 0);
    check("abort_borrow", int'(bus.borrow_out), 0);
    @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    repeat (2 * W) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) seen++;
    end
    check("abort_no_done", seen, 0);
    op("09_04", 8'h09, 8'h04, 1'b0);
    check("09_04_lit", int'(bus.diff), 'h05);

    // start held high: captures at cycle 0, then every W+2 cycles
    cap = 0;
    n = 0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 0; c < 48 && n < 3; c++) begin
      qa[c] = W'($urandom);
      qb[c] = W'($urandom);
      bus.A = qa[c];
      bus.B = qb[c];
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        check("b2b_spacing", c, cap + W);
        check_result("b2b", qa[cap], qb[cap]);
        n++;
        cap = c + 2;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("b2b_count", n, 3);
    repeat (2) @(posedge clk);

    for (int i = 0; i < 10; i++)
      op("rand", W'($urandom), W'($urandom), 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
